// File: rtl/memory_stage.sv
// memory_stage: fourth pipeline stage of the 16-bit MISC-V core.
//
// Purpose:
//   Performs data-memory loads and stores over a req/ack handshake. The
//   handshake may take several cycles. While an access is outstanding the
//   stage raises stall, which freezes everything upstream. An access that
//   waits too long is aborted, and the sticky mem_err flag is raised. The
//   stage also holds the MEM/WB pipeline register that feeds writeback.
//
// Handshake:
//   dmem_req is held high for as long as a memory op is present on the
//   EX/MEM inputs. The access completes in the first cycle where
//   dmem_req && dmem_ack are both high. dmem_rdata is only meaningful in
//   that cycle. Inputs stay stable during a wait because upstream is stalled.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   IRegWrite, IMemWrite, IMemRead EX/MEM control bits
//   IRegStore                      writeback source select
//   IPCP2, IALUResult, I3rdArg     PC+2, ALU result / address, store data
//   IRs1, IRs2, IRd                register indices
//   dmem_req/we/addr/wdata         data-memory request side
//   dmem_rdata, dmem_ack           data-memory response side
//   stall                          hold PC, IF/ID, ID/EX, EX/MEM
//   ALUResultMEM                   combinational forwarding copy of IALUResult
//   O*                             MEM/WB pipeline register
//   mem_err                        sticky access-timeout flag
//   dbgState, dbgWaitCnt           FSM state (0 idle, 1 waiting) and wait counter
module memory_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRegWrite,
    input  logic              IMemWrite,
    input  logic              IMemRead,
    input  logic [1:0]        IRegStore,
    input  logic [DATA_W-1:0] IPCP2,
    input  logic [DATA_W-1:0] IALUResult,
    input  logic [DATA_W-1:0] I3rdArg,
    input  logic [REG_W-1:0]  IRs1,
    input  logic [REG_W-1:0]  IRs2,
    input  logic [REG_W-1:0]  IRd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] ALUResultMEM,
    output logic              ORegWrite,
    output logic [1:0]        ORegStore,
    output logic [DATA_W-1:0] OPCP2,
    output logic [DATA_W-1:0] OALUResult,
    output logic [DATA_W-1:0] OLoadData,
    output logic [REG_W-1:0]  ORs1,
    output logic [REG_W-1:0]  ORs2,
    output logic [REG_W-1:0]  ORd,
    output logic              mem_err,
    output logic              dbgState,
    output logic [3:0]        dbgWaitCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t     state, nextState;
    logic [3:0] waitCnt, nextWaitCnt;
    logic       memop;
    logic       abort;
    logic       isLoad;

    // When both request bits are set, the access is treated as a store.
    assign memop  = IMemRead | IMemWrite;
    assign isLoad = IMemRead & ~IMemWrite;

    assign dmem_req     = memop & ~reset;
    assign dmem_we      = IMemWrite;
    assign dmem_addr    = IALUResult;
    assign dmem_wdata   = I3rdArg;
    assign ALUResultMEM = IALUResult;

    assign dbgState   = state;
    assign dbgWaitCnt = waitCnt;

    // An abort releases stall in the same cycle. The aborted instruction
    // then leaves through MEM/WB with its writeback suppressed.
    assign stall = memop & ~dmem_ack & ~abort & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (memop && !dmem_ack) begin
                    nextState   = WAIT;
                    nextWaitCnt = 4'd1;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    nextState   = IDLE;
                    nextWaitCnt = 4'd0;
                end else if (waitCnt == TIMEOUT_CNT) begin
                    abort       = 1'b1;
                    nextState   = IDLE;
                    nextWaitCnt = 4'd0;
                end else begin
                    nextWaitCnt = waitCnt + 4'd1;
                end
            end
            default: begin
                nextState   = IDLE;
                nextWaitCnt = 4'd0;
            end
        endcase
    end

    // MEM/WB register. While stalled it captures a bubble, so writeback can
    // never see the same instruction twice. PC+2 and the ALU result hold
    // their values because no writeback is enabled to consume them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ORegWrite  <= 1'b0;
            ORegStore  <= 2'd0;
            OPCP2      <= '0;
            OALUResult <= '0;
            OLoadData  <= '0;
            ORs1       <= '0;
            ORs2       <= '0;
            ORd        <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (stall) begin
                ORegWrite <= 1'b0;
                ORegStore <= 2'd0;
                OLoadData <= '0;
                ORs1      <= '0;
                ORs2      <= '0;
                ORd       <= '0;
            end else begin
                // Stores never write the register file.
                ORegWrite  <= IRegWrite & ~IMemWrite & ~abort;
                ORegStore  <= IRegStore;
                OPCP2      <= IPCP2;
                OALUResult <= IALUResult;
                OLoadData  <= (isLoad && !abort) ? dmem_rdata : '0;
                ORs1       <= IRs1;
                ORs2       <= IRs2;
                ORd        <= IRd;
            end
            if (abort) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule
